// File: rtl/inst_encode_pkg.sv
// Shared RV32I encoding definitions: format codes, major opcodes, field
// positions and the immediate range helper used by the packer.
package inst_encode_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  // Bit positions of the fixed register/function fields; shared with the decoder.
  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNC3_LSB  = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNC7_LSB  = 25;

  typedef struct packed {
    logic [31:0] inst;
    logic        illegal;
  } pack_res_t;

  // True when v[31:top] are all copies of one bit, i.e. the signed value
  // survives truncation to top+1 bits.
  function automatic logic imm_fits(input logic [31:0] v, input int top);
    logic signed [31:0] sv;
    logic signed [31:0] t;
    int                 sh;
    sh = 31 - top;
    sv = $signed(v);
    t  = sv <<< sh;
    t  = t >>> sh;
    return (t == sv);
  endfunction

endpackage

// File: rtl/inst_encode_pack.sv
// Combinational RV32I field packer with encodability check.
module inst_pack
  import inst_encode_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output pack_res_t   res
);

  logic [31:0] inst;
  logic        ok;

  // Scatter fields into the word for the selected format and flag anything
  // the format cannot represent.
  always_comb begin
    inst                    = '0;
    inst[OPCODE_LSB +: 7]   = opcode;
    ok                      = (opcode[1:0] == 2'b11);
    case (fmt)
      FMT_R: begin
        inst[RD_LSB    +: 5] = rd;
        inst[FUNC3_LSB +: 3] = func3;
        inst[RS1_LSB   +: 5] = rs1;
        inst[RS2_LSB   +: 5] = rs2;
        inst[FUNC7_LSB +: 7] = func7;
      end
      FMT_I: begin
        inst[RD_LSB    +: 5] = rd;
        inst[FUNC3_LSB +: 3] = func3;
        inst[RS1_LSB   +: 5] = rs1;
        inst[31:20]          = imm[11:0];
        ok                   = ok & imm_fits(imm, 11);
      end
      FMT_S: begin
        inst[11:7]           = imm[4:0];
        inst[FUNC3_LSB +: 3] = func3;
        inst[RS1_LSB   +: 5] = rs1;
        inst[RS2_LSB   +: 5] = rs2;
        inst[31:25]          = imm[11:5];
        ok                   = ok & imm_fits(imm, 11);
      end
      FMT_B: begin
        inst[7]              = imm[11];
        inst[11:8]           = imm[4:1];
        inst[FUNC3_LSB +: 3] = func3;
        inst[RS1_LSB   +: 5] = rs1;
        inst[RS2_LSB   +: 5] = rs2;
        inst[30:25]          = imm[10:5];
        inst[31]             = imm[12];
        ok                   = ok & imm_fits(imm, 12) & ~imm[0];
      end
      FMT_U: begin
        inst[RD_LSB +: 5]    = rd;
        inst[31:12]          = imm[31:12];
        ok                   = ok & (imm[11:0] == 12'd0);
      end
      FMT_J: begin
        inst[RD_LSB +: 5]    = rd;
        inst[19:12]          = imm[19:12];
        inst[20]             = imm[11];
        inst[30:21]          = imm[10:1];
        inst[31]             = imm[20];
        ok                   = ok & imm_fits(imm, 20) & ~imm[0];
      end
      default: begin
        ok                   = 1'b0;
      end
    endcase
  end

  assign res.inst    = inst;
  assign res.illegal = ~ok;

endmodule

// File: rtl/inst_encode.sv
// RV32I instruction encoder: packs descriptors, stamps sequential byte
// addresses and streams words out through a 2-entry buffer.
module inst_encode
  import inst_encode_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ERR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  pack_res_t res;

  inst_pack u_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .func3  (func3),
    .func7  (func7),
    .imm    (imm),
    .res    (res)
  );

  // Entry 0 is always the head; entry 1 only holds a word when count is 2.
  logic [1:0]        count_q, count_d;
  logic              rdy_en_q, rdy_en_d;
  logic [31:0]       inst0_q, inst0_d, inst1_q, inst1_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic       pop, accept, push, reject;
  logic [1:0] slot;

  assign in_ready  = rdy_en_q & (count_q != 2'd2) & ~clear;
  assign out_valid = (count_q != 2'd0);
  assign out_inst  = inst0_q;
  assign out_addr  = addr0_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  assign pop    = out_valid & out_ready;
  assign accept = in_valid & in_ready;
  assign push   = accept & ~res.illegal;
  assign reject = accept & res.illegal;
  assign slot   = count_q - 2'(pop);

  // Next-state for buffer, address counter and error tracking; clear wins.
  always_comb begin
    count_d   = count_q;
    rdy_en_d  = 1'b1;
    inst0_d   = inst0_q;
    inst1_d   = inst1_q;
    addr0_d   = addr0_q;
    addr1_d   = addr1_q;
    addr_d    = addr_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      count_d   = 2'd0;
      inst0_d   = '0;
      addr0_d   = BASE_ADDR;
      addr_d    = BASE_ADDR;
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else begin
      if (pop) begin
        inst0_d = inst1_q;
        addr0_d = addr1_q;
      end
      if (push) begin
        if (slot == 2'd0) begin
          inst0_d = res.inst;
          addr0_d = addr_q;
        end else begin
          inst1_d = res.inst;
          addr1_d = addr_q;
        end
        addr_d = addr_q + ADDR_W'(4);
      end
      count_d = count_q - 2'(pop) + 2'(push);
      if (reject) begin
        err_d = 1'b1;
        if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  // State registers with asynchronous reset to the idle, empty condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 2'd0;
      rdy_en_q  <= 1'b0;
      inst0_q   <= '0;
      inst1_q   <= '0;
      addr0_q   <= BASE_ADDR;
      addr1_q   <= BASE_ADDR;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      rdy_en_q  <= rdy_en_d;
      inst0_q   <= inst0_d;
      inst1_q   <= inst1_d;
      addr0_q   <= addr0_d;
      addr1_q   <= addr1_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
